// File: rtl/s3_pkg.sv
// Shared FSM state, mod-3 residue type and coefficient<->residue conversions.
// Latency: none; types and pure functions only.
// Backpressure: not applicable.
package s3_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_MUL  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Mod-3 residue: 0, 1 or 2, where 2 stands for -1. Code 3 never occurs.
   typedef logic [1:0] res_t;

   localparam res_t RES_ZERO = 2'd0;
   localparam res_t RES_POS  = 2'd1;
   localparam res_t RES_NEG  = 2'd2;

   // Widest coefficient the conversion helpers can handle.
   localparam int MAX_W = 64;

   function automatic res_t res_neg(input res_t r);
      case (r)
         RES_POS: return RES_NEG;
         RES_NEG: return RES_POS;
         default: return RES_ZERO;
      endcase
   endfunction

   // All-ones pattern of a w-bit coefficient, zero-extended to MAX_W.
   function automatic logic [MAX_W-1:0] width_ones(input int w);
      if (w >= MAX_W) return '1;
      return (MAX_W'(1) << w) - MAX_W'(1);
   endfunction

   // Caller zero-extends the coefficient; anything but 0, +1, -1 reads as zero.
   function automatic res_t coef_to_res(input logic [MAX_W-1:0] c, input int w);
      if (c == MAX_W'(1))          return RES_POS;
      else if (c == width_ones(w)) return RES_NEG;
      else                         return RES_ZERO;
   endfunction

   // Caller truncates the result back to its coefficient width.
   function automatic logic [MAX_W-1:0] res_to_coef(input res_t r, input int w);
      case (r)
         RES_POS: return MAX_W'(1);
         RES_NEG: return width_ones(w);
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/s3_mac.sv
// One lane of the multiplier: acc + a*b reduced mod 3.
// Latency: purely combinational.
// Backpressure: none; sampled by the owning lane register.
module s3_mac
   import s3_pkg::*;
(
   input  res_t acc,
   input  res_t a,
   input  res_t b,
   output res_t sum
);

   res_t       prod;
   logic [2:0] raw;

   // Trit product (+1 when signs agree, -1 otherwise), then add with a single wrap.
   always_comb begin
      prod = RES_ZERO;
      if (a != RES_ZERO && b != RES_ZERO) begin
         prod = (a == b) ? RES_POS : RES_NEG;
      end
      raw = {1'b0, acc} + {1'b0, prod};
      sum = (raw >= 3'd3) ? res_t'(raw - 3'd3) : raw[1:0];
   end

endmodule

// File: rtl/s3_poly_mul.sv
// Multiplies two length-N ternary polynomials mod x^N-1 or x^N+1, N lanes in parallel.
// Latency: first output N+1 cycles after the last input beat; one step per cycle.
// Backpressure: in_ready only in LOAD; output index advances on out_valid && out_ready.
module s3_poly_mul
   import s3_pkg::*;
#(
   parameter int N = 701,
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_coef,
   output logic         out_last,
   output logic         busy
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t        state;
   logic [IW-1:0] beat_idx;
   logic [IW-1:0] step_idx;
   logic [IW-1:0] out_idx;
   logic [IW-1:0] out_nxt;
   logic          mode_r;

   res_t a_r     [N];
   res_t brot    [N];
   res_t acc     [N];
   res_t mac_out [N];
   res_t a_step;

   assign a_step  = a_r[step_idx];
   assign out_nxt = out_idx + IW'(1);

   // Every lane multiplies the same a[i] by its own rotated b coefficient.
   for (genvar j = 0; j < N; j++) begin : g_mac
      s3_mac u_mac (
         .acc (acc[j]),
         .a   (a_step),
         .b   (brot[j]),
         .sum (mac_out[j])
      );
   end

   // Coefficient store, rotating b and the accumulators; re-initialised by beat 0.
   always_ff @(posedge clk) begin
      if (state == ST_LOAD && in_valid) begin
         a_r[beat_idx]  <= coef_to_res(MAX_W'(in_a), W);
         brot[beat_idx] <= coef_to_res(MAX_W'(in_b), W);
         if (beat_idx == '0) begin
            for (int j = 0; j < N; j++) acc[j] <= RES_ZERO;
         end
      end else if (state == ST_MUL) begin
         for (int j = 0; j < N; j++) acc[j] <= mac_out[j];
         for (int j = 1; j < N; j++) brot[j] <= brot[j-1];
         brot[0] <= mode_r ? res_neg(brot[N-1]) : brot[N-1];
      end
   end

   // Sequencer LOAD -> MUL -> OUT with registered handshake and output signals.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_LOAD;
         beat_idx  <= '0;
         step_idx  <= '0;
         out_idx   <= '0;
         mode_r    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         out_coef  <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid) begin
                  if (beat_idx == '0) mode_r <= mode;
                  if (beat_idx == LAST_IDX) begin
                     beat_idx <= '0;
                     state    <= ST_MUL;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end else begin
                     beat_idx <= beat_idx + IW'(1);
                  end
               end
            end
            ST_MUL: begin
               if (step_idx == LAST_IDX) begin
                  // acc[0] is still being written this cycle, so take the lane result.
                  step_idx  <= '0;
                  state     <= ST_OUT;
                  out_idx   <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  out_coef  <= W'(res_to_coef(mac_out[0], W));
               end else begin
                  step_idx <= step_idx + IW'(1);
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  if (out_idx == LAST_IDX) begin
                     state     <= ST_LOAD;
                     out_idx   <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_coef  <= '0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                  end else begin
                     out_idx  <= out_nxt;
                     out_coef <= W'(res_to_coef(acc[out_nxt], W));
                     out_last <= (out_nxt == LAST_IDX);
                  end
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_s3_poly_mul.sv
// Bench for s3_poly_mul at N=7 and N=701 with a queue-based scoreboard.
// Latency: checks first out_valid N+1 cycles after the last accepted beat.
// Backpressure: exercises stalled, patterned and random out_ready.
`timescale 1ns/1ps
module tb_s3_poly_mul;

   localparam int W  = 13;
   localparam int NS = 7;
   localparam int NL = 701;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         mode;
   logic         out_ready;
   logic         sel;

   logic         s_in_ready, s_out_valid, s_out_last, s_busy;
   logic [W-1:0] s_out_coef;
   logic         l_in_ready, l_out_valid, l_out_last, l_busy;
   logic [W-1:0] l_out_coef;

   logic         m_in_ready, m_out_valid, m_out_last, m_busy;
   logic [W-1:0] m_out_coef;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   int a_code[];
   int b_code[];

   always #5 clk = ~clk;

   s3_poly_mul #(.N(NS), .W(W)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .mode(mode), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_coef(s_out_coef), .out_last(s_out_last), .busy(s_busy)
   );

   s3_poly_mul #(.N(NL), .W(W)) u_dut_l (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(l_in_ready),
      .in_a(in_a), .in_b(in_b), .mode(mode), .out_valid(l_out_valid),
      .out_ready(out_ready), .out_coef(l_out_coef), .out_last(l_out_last), .busy(l_busy)
   );

   assign m_in_ready  = sel ? l_in_ready  : s_in_ready;
   assign m_out_valid = sel ? l_out_valid : s_out_valid;
   assign m_out_last  = sel ? l_out_last  : s_out_last;
   assign m_busy      = sel ? l_busy      : s_busy;
   assign m_out_coef  = sel ? l_out_coef  : s_out_coef;

   // Codes: 0 -> 0, 1 -> +1, 2 -> -1, 3 -> illegal pattern that must read as 0.
   function automatic logic [W-1:0] enc(input int code);
      case (code)
         0:       return '0;
         1:       return W'(1);
         2:       return '1;
         default: return W'(5);
      endcase
   endfunction

   function automatic int val(input int code);
      case (code)
         1:       return 1;
         2:       return -1;
         default: return 0;
      endcase
   endfunction

   task automatic gen_rand(input int n);
      a_code = new[n];
      b_code = new[n];
      for (int k = 0; k < n; k++) begin
         a_code[k] = $urandom_range(0, 3);
         b_code[k] = $urandom_range(0, 3);
      end
   endtask

   // Schoolbook product; terms wrapping past x^N pick up the mode's sign.
   task automatic model_push(input int n, input bit md);
      for (int j = 0; j < n; j++) begin
         int s;
         s = 0;
         for (int i = 0; i < n; i++) begin
            int k;
            k = j - i;
            if (k < 0) begin
               k = k + n;
               s = s + (md ? -1 : 1) * val(a_code[i]) * val(b_code[k]);
            end else begin
               s = s + val(a_code[i]) * val(b_code[k]);
            end
         end
         s = ((s % 3) + 3) % 3;
         exp_q.push_back(enc(s));
      end
   endtask

   task automatic load_beats(input int n, input bit md, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid  = 1'b0;
            in_a      = '1;
            in_b      = W'(1);
            mode      = !md;
            @(posedge clk); #1;
         end
         checks++;
         if (m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_beat%0d: got %b, want 1", k, m_in_ready);
         end
         in_valid  = 1'b1;
         in_a      = enc(a_code[k]);
         in_b      = enc(b_code[k]);
         mode      = (k == 0) ? md : !md;
         out_ready = 1'(($urandom_range(0, 1)));
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   // Called #1 after the edge that accepted the last beat.
   task automatic wait_first(input int n);
      int e;
      bit got;
      e   = 0;
      got = 0;
      checks++;
      if (m_busy !== 1'b1 || m_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mul_entry: busy=%b in_ready=%b, want busy=1 in_ready=0", m_busy, m_in_ready);
      end
      // Offer junk while busy; it must be ignored.
      in_valid  = 1'b1;
      in_a      = W'(1);
      in_b      = '1;
      out_ready = 1'b1;
      while (!got && e <= n + 4) begin
         if (m_out_valid === 1'b1) got = 1;
         else begin
            @(posedge clk); #1;
            e++;
         end
      end
      checks++;
      if (!got || e + 1 != n + 1) begin
         errors++;
         $display("FAIL latency: got %0d cycles (seen=%0b), want %0d", e + 1, got, n + 1);
      end
   endtask

   // rmode 0: always ready, 1: 1-0-0-1 pattern, 2: random.
   task automatic collect(input int n, input int rmode);
      int cnt, cyc;
      logic [W-1:0] exp_c, pc;
      logic pl, exp_last;
      bit stalled, rdy;
      in_valid = 1'b0;
      cnt = 0;
      cyc = 0;
      stalled = 0;
      pc = '0;
      pl = 1'b0;
      while (cnt < n && cyc < 8 * n + 20) begin
         rdy = 0;
         if (m_out_valid === 1'b1) begin
            if (stalled) begin
               checks++;
               if (m_out_coef !== pc || m_out_last !== pl) begin
                  errors++;
                  $display("FAIL stall_hold%0d: coef=%h last=%b, want coef=%h last=%b", cnt, m_out_coef, m_out_last, pc, pl);
               end
            end
            case (rmode)
               0:       rdy = 1;
               1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (rdy) begin
               exp_last = (cnt == n - 1);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL scoreboard_empty: coef=%h at index %0d, want queued value", m_out_coef, cnt);
               end else begin
                  exp_c = exp_q.pop_front();
                  if (m_out_coef !== exp_c) begin
                     errors++;
                     $display("FAIL coef[%0d]: got %h, want %h", cnt, m_out_coef, exp_c);
                  end
               end
               checks++;
               if (m_out_last !== exp_last) begin
                  errors++;
                  $display("FAIL out_last[%0d]: got %b, want %b", cnt, m_out_last, exp_last);
               end
               cnt++;
               stalled = 0;
            end else begin
               stalled = 1;
               pc = m_out_coef;
               pl = m_out_last;
            end
         end else begin
            checks++;
            errors++;
            $display("FAIL valid_drop: out_valid=%b at index %0d, want 1", m_out_valid, cnt);
         end
         out_ready = rdy;
         @(posedge clk); #1;
         out_ready = 1'b0;
         cyc++;
      end
      checks++;
      if (cnt != n) begin
         errors++;
         $display("FAIL transfers: got %0d, want %0d", cnt, n);
      end
      checks++;
      if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_busy !== 1'b0) begin
         errors++;
         $display("FAIL back_to_load: valid=%b in_ready=%b busy=%b, want 0 1 0", m_out_valid, m_in_ready, m_busy);
      end
   endtask

   task automatic do_run(input int n, input bit md, input int rmode, input bit use_model, input bit gaps);
      sel = (n == NL);
      if (use_model) model_push(n, md);
      load_beats(n, md, gaps);
      wait_first(n);
      collect(n, rmode);
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; mode = 1'b0; out_ready = 1'b0; sel = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (s_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, want 1", s_in_ready); end
      checks++;
      if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, want 0", s_out_valid); end
      checks++;
      if (s_out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b, want 0", s_out_last); end
      checks++;
      if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, want 0", s_busy); end
      checks++;
      if (s_out_coef !== '0) begin errors++; $display("FAIL rst_out_coef: got %h, want 0", s_out_coef); end
      checks++;
      if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0 || l_out_last !== 1'b0 || l_busy !== 1'b0 || l_out_coef !== '0) begin
         errors++;
         $display("FAIL rst_large: rdy=%b vld=%b last=%b busy=%b coef=%h, want 1 0 0 0 0", l_in_ready, l_out_valid, l_out_last, l_busy, l_out_coef);
      end
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_identity();
      int bv[7] = '{1, 2, 0, 1, 0, 0, 2};
      a_code = new[NS];
      b_code = new[NS];
      for (int k = 0; k < NS; k++) begin
         a_code[k] = 0;
         b_code[k] = bv[k];
         exp_q.push_back(enc(bv[k]));
      end
      a_code[0] = 1;
      do_run(NS, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_monomial();
      for (int md = 0; md < 2; md++) begin
         a_code = new[NS];
         b_code = new[NS];
         for (int k = 0; k < NS; k++) begin
            a_code[k] = 0;
            b_code[k] = 0;
         end
         a_code[1] = 1;
         b_code[6] = 1;
         exp_q.push_back(md == 0 ? enc(1) : enc(2));
         for (int k = 1; k < NS; k++) exp_q.push_back(enc(0));
         do_run(NS, 1'(md), 0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_all_neg();
      int neg_exp[7] = '{1, 0, 2, 1, 0, 2, 1};
      for (int md = 0; md < 2; md++) begin
         a_code = new[NS];
         b_code = new[NS];
         for (int k = 0; k < NS; k++) begin
            a_code[k] = 2;
            b_code[k] = 2;
            exp_q.push_back(md == 0 ? enc(1) : enc(neg_exp[k]));
         end
         do_run(NS, 1'(md), 0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_stall();
      gen_rand(NS);
      do_run(NS, 1'b1, 1, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_mul();
      bit seen;
      sel = 1'b0;
      gen_rand(NS);
      load_beats(NS, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_now: rdy=%b vld=%b busy=%b, want 1 0 0", s_in_ready, s_out_valid, s_busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (s_in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b, want 1", s_in_ready); end
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (s_out_valid !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL mid_rst_output: out_valid seen=1, want 0"); end
      gen_rand(NS);
      do_run(NS, 1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 200; r++) begin
         gen_rand(NS);
         do_run(NS, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b1, 1'b1);
      end
      for (int r = 0; r < 10; r++) begin
         gen_rand(NL);
         do_run(NL, 1'(r % 2), (r < 2) ? 0 : 2, 1'b1, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_monomial();
      test_all_neg();
      test_stall();
      test_reset_mid_mul();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

endmodule
